// File: rtl/vga_timing.sv
// VGA raster timing generator: h/v counters, registered pixel strobes and delayed active-low syncs.
// Optional frame counter output is enabled by defining VGA_TIMING_FRAME_COUNT_EN.
module vga_timing #(
  parameter int unsigned H_ACTIVE   = 640,
  parameter int unsigned H_FP       = 16,
  parameter int unsigned H_SYNC     = 96,
  parameter int unsigned H_BP       = 48,
  parameter int unsigned V_ACTIVE   = 480,
  parameter int unsigned V_FP       = 10,
  parameter int unsigned V_SYNC     = 2,
  parameter int unsigned V_BP       = 33,
  parameter int unsigned SYNC_DELAY = 2
) (
  input  logic        clk,
  input  logic        resetn,
  output logic [9:0]  pixel_x,
  output logic [9:0]  pixel_y,
  output logic        pixel_valid,
  output logic        line_start,
  output logic        frame_start,
  output logic        vga_hsync,
  output logic        vga_vsync
`ifdef VGA_TIMING_FRAME_COUNT_EN
  ,
  output logic [15:0] frame_count
`endif
);

  localparam int unsigned H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int unsigned V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;
  localparam int unsigned HW      = (H_TOTAL > 1) ? $clog2(H_TOTAL) : 1;
  localparam int unsigned VW      = (V_TOTAL > 1) ? $clog2(V_TOTAL) : 1;

  logic [HW-1:0]         h;
  logic [VW-1:0]         v;
  logic [SYNC_DELAY:0]   hs_pipe;
  logic [SYNC_DELAY:0]   vs_pipe;

  logic h_last_c;
  logic v_last_c;
  logic active_c;
  logic hsync_raw_c;
  logic vsync_raw_c;

  // Position decode of the counter value that the output register is about to present.
  always_comb begin
    h_last_c    = (32'(h) == H_TOTAL - 1);
    v_last_c    = (32'(v) == V_TOTAL - 1);
    active_c    = (32'(h) < H_ACTIVE) && (32'(v) < V_ACTIVE);
    hsync_raw_c = !((32'(h) >= H_ACTIVE + H_FP) && (32'(h) < H_ACTIVE + H_FP + H_SYNC));
    vsync_raw_c = !((32'(v) >= V_ACTIVE + V_FP) && (32'(v) < V_ACTIVE + V_FP + V_SYNC));
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      h           <= '0;
      v           <= '0;
      pixel_valid <= 1'b0;
      pixel_x     <= '0;
      pixel_y     <= '0;
      line_start  <= 1'b0;
      frame_start <= 1'b0;
      hs_pipe     <= '1;
      vs_pipe     <= '1;
    end else begin
      // h and v wrap on the same edge at end of frame.
      h <= h_last_c ? '0 : h + HW'(1);
      if (h_last_c) begin
        v <= v_last_c ? '0 : v + VW'(1);
      end
      pixel_valid <= active_c;
      pixel_x     <= active_c ? 10'(h) : 10'd0;
      pixel_y     <= active_c ? 10'(v) : 10'd0;
      line_start  <= (h == '0);
      frame_start <= (h == '0) && (v == '0);
      // Stage 0 is the output register; stages above it add SYNC_DELAY cycles of lag.
      hs_pipe[0]  <= hsync_raw_c;
      vs_pipe[0]  <= vsync_raw_c;
      for (int i = 1; i <= int'(SYNC_DELAY); i++) begin
        hs_pipe[i] <= hs_pipe[i-1];
        vs_pipe[i] <= vs_pipe[i-1];
      end
    end
  end

  assign vga_hsync = hs_pipe[SYNC_DELAY];
  assign vga_vsync = vs_pipe[SYNC_DELAY];

`ifdef VGA_TIMING_FRAME_COUNT_EN
  // Advances on the same edge that raises frame_start.
  always_ff @(posedge clk) begin
    if (!resetn) begin
      frame_count <= '0;
    end else if ((h == '0) && (v == '0)) begin
      frame_count <= frame_count + 16'd1;
    end
  end
`endif

endmodule

// File: tb/tb_vga_timing.sv
// Randomized bench for vga_timing with small raster parameters, checked against an arithmetic model.
module tb_vga_timing;

  localparam int HA = 16, HFP = 4, HS = 6, HBP = 5;
  localparam int VA = 8,  VFP = 2, VS = 2, VBP = 3;
  localparam int HT = HA + HFP + HS + HBP;
  localparam int VT = VA + VFP + VS + VBP;
  localparam int FT = HT * VT;
  localparam int SD = 2;

  logic       clk = 1'b0;
  logic       resetn = 1'b0;
  logic [9:0] pixel_x, pixel_y, pixel_x0, pixel_y0;
  logic       pixel_valid, line_start, frame_start, vga_hsync, vga_vsync;
  logic       pixel_valid0, line_start0, frame_start0, vga_hsync0, vga_vsync0;
`ifdef VGA_TIMING_FRAME_COUNT_EN
  logic [15:0] frame_count, frame_count0;
`endif

  int vectors = 0;
  int miscompares = 0;

  always #5 clk = ~clk;

  vga_timing #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
               .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_DELAY(SD)) dut (
    .clk(clk), .resetn(resetn), .pixel_x(pixel_x), .pixel_y(pixel_y),
    .pixel_valid(pixel_valid), .line_start(line_start), .frame_start(frame_start),
    .vga_hsync(vga_hsync), .vga_vsync(vga_vsync)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_count(frame_count)
`endif
  );

  vga_timing #(.H_ACTIVE(HA), .H_FP(HFP), .H_SYNC(HS), .H_BP(HBP),
               .V_ACTIVE(VA), .V_FP(VFP), .V_SYNC(VS), .V_BP(VBP), .SYNC_DELAY(0)) dut0 (
    .clk(clk), .resetn(resetn), .pixel_x(pixel_x0), .pixel_y(pixel_y0),
    .pixel_valid(pixel_valid0), .line_start(line_start0), .frame_start(frame_start0),
    .vga_hsync(vga_hsync0), .vga_vsync(vga_vsync0)
`ifdef VGA_TIMING_FRAME_COUNT_EN
    , .frame_count(frame_count0)
`endif
  );

  logic [24:0] obs;
  assign obs = {pixel_valid, line_start, frame_start, vga_hsync, vga_vsync, pixel_x, pixel_y};

  localparam logic [24:0] RST_VAL = {1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 10'd0, 10'd0};

  // Expected outputs n cycles after reset release, for a sync lag of d cycles.
  function automatic logic [24:0] model(input int n, input int d);
    int h, v, p, ph, pv;
    logic valid, hs, vs;
    h = n % HT;
    v = (n / HT) % VT;
    valid = (h < HA) && (v < VA);
    p = n - d;
    if (p < 0) begin
      hs = 1'b1;
      vs = 1'b1;
    end else begin
      ph = p % HT;
      pv = (p / HT) % VT;
      hs = !((ph >= HA + HFP) && (ph < HA + HFP + HS));
      vs = !((pv >= VA + VFP) && (pv < VA + VFP + VS));
    end
    return {valid, (h == 0), (h == 0) && (v == 0), hs, vs,
            valid ? 10'(h) : 10'd0, valid ? 10'(v) : 10'd0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Leaves the bench at n = 0 (first cycle after release).
  task automatic do_reset(input int cycles);
    resetn = 1'b0;
    repeat (cycles) step();
    resetn = 1'b1;
    step();
  endtask

  task automatic test_reset();
    logic [24:0] exp;
    resetn = 1'b0;
    step();
    step();
    vectors++;
    if (obs !== RST_VAL) begin
      miscompares++;
      $display("FAIL reset_state: got %h expected %h", obs, RST_VAL);
    end
    vectors++;
    if ({vga_hsync0, vga_vsync0} !== 2'b11) begin
      miscompares++;
      $display("FAIL reset_sync_d0: got %b expected 11", {vga_hsync0, vga_vsync0});
    end
`ifdef VGA_TIMING_FRAME_COUNT_EN
    vectors++;
    if (frame_count !== 16'd0) begin
      miscompares++;
      $display("FAIL reset_frame_count: got %0d expected 0", frame_count);
    end
`endif
    resetn = 1'b1;
    step();
    exp = {1'b1, 1'b1, 1'b1, 1'b1, 1'b1, 10'd0, 10'd0};
    vectors++;
    if (obs !== exp) begin
      miscompares++;
      $display("FAIL first_cycle: got %h expected %h", obs, exp);
    end
  endtask

  task automatic test_line();
    int hi = 0, lo = 0, extra_ls = 0;
    do_reset($urandom_range(4, 1));
    for (int n = 0; n < HT; n++) begin
      if (pixel_valid && lo == 0) hi++;
      else if (!pixel_valid) lo++;
      if (n > 0 && line_start) extra_ls++;
      step();
    end
    vectors++;
    if (hi !== HA || lo !== HT - HA) begin
      miscompares++;
      $display("FAIL line_valid_run: got high %0d low %0d expected high %0d low %0d", hi, lo, HA, HT - HA);
    end
    vectors++;
    if (line_start !== 1'b1 || extra_ls !== 0) begin
      miscompares++;
      $display("FAIL line_period: got line_start %b extra %0d expected 1 and 0", line_start, extra_ls);
    end
  endtask

  task automatic test_sync();
    int n = 0, fall = -1, len = 0;
    do_reset(1);
    while (vga_hsync !== 1'b0 && n < 2 * HT) begin step(); n++; end
    fall = n;
    while (vga_hsync === 1'b0 && len < 2 * HT) begin step(); n++; len++; end
    vectors++;
    if (fall !== HA + HFP + SD || len !== HS) begin
      miscompares++;
      $display("FAIL hsync_window: got start %0d len %0d expected start %0d len %0d",
               fall, len, HA + HFP + SD, HS);
    end
    while (vga_vsync !== 1'b0 && n < 2 * FT) begin step(); n++; end
    fall = n;
    len = 0;
    while (vga_vsync === 1'b0 && len < 2 * FT) begin step(); n++; len++; end
    vectors++;
    if (fall !== (VA + VFP) * HT + SD || len !== VS * HT) begin
      miscompares++;
      $display("FAIL vsync_window: got start %0d len %0d expected start %0d len %0d",
               fall, len, (VA + VFP) * HT + SD, VS * HT);
    end
  endtask

  task automatic test_frames();
    logic [24:0] exp, exp0;
    int fs_cnt = 0, last_fs = -1, bad_gap = 0, max_y = 0;
    do_reset($urandom_range(4, 1));
    for (int n = 0; n < 2 * FT + 4; n++) begin
      exp  = model(n, SD);
      exp0 = model(n, 0);
      vectors++;
      if (obs !== exp) begin
        miscompares++;
        $display("FAIL frame_cycle n=%0d: got %h expected %h", n, obs, exp);
      end
      vectors++;
      if ({vga_hsync0, vga_vsync0} !== exp0[21:20]) begin
        miscompares++;
        $display("FAIL sync_d0 n=%0d: got %b expected %b", n, {vga_hsync0, vga_vsync0}, exp0[21:20]);
      end
      if (frame_start) begin
        if (last_fs >= 0 && n - last_fs != FT) bad_gap++;
        last_fs = n;
        fs_cnt++;
      end
      if (int'(pixel_y) > max_y) max_y = int'(pixel_y);
      step();
    end
    vectors++;
    if (fs_cnt !== 3 || bad_gap !== 0) begin
      miscompares++;
      $display("FAIL frame_period: got %0d pulses %0d bad gaps expected 3 and 0", fs_cnt, bad_gap);
    end
    vectors++;
    if (max_y !== VA - 1) begin
      miscompares++;
      $display("FAIL max_pixel_y: got %0d expected %0d", max_y, VA - 1);
    end
  endtask

  task automatic test_mid_reset();
    logic [24:0] exp;
    int run, hold;
    for (int k = 0; k < 4; k++) begin
      do_reset(1);
      run  = $urandom_range(FT + FT / 2, 5);
      hold = (k == 0) ? 3 : $urandom_range(4, 1);
      for (int n = 0; n < run; n++) begin
        exp = model(n, SD);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL pre_reset n=%0d: got %h expected %h", n, obs, exp);
        end
        step();
      end
      resetn = 1'b0;
      for (int c = 0; c < hold; c++) begin
        step();
        vectors++;
        if (obs !== RST_VAL) begin
          miscompares++;
          $display("FAIL mid_reset_hold run=%0d: got %h expected %h", run, obs, RST_VAL);
        end
      end
      resetn = 1'b1;
      step();
      for (int n = 0; n < 3 * HT; n++) begin
        exp = model(n, SD);
        vectors++;
        if (obs !== exp) begin
          miscompares++;
          $display("FAIL post_reset n=%0d: got %h expected %h", n, obs, exp);
        end
        step();
      end
    end
  endtask

`ifdef VGA_TIMING_FRAME_COUNT_EN
  task automatic test_frame_count();
    int waited;
    do_reset(2);
    for (int k = 1; k <= 3; k++) begin
      waited = 0;
      while (frame_start !== 1'b1 && waited < FT + 2) begin step(); waited++; end
      if (frame_start !== 1'b1) begin
        vectors++;
        miscompares++;
        $display("FAIL frame_count_wait: got no frame_start expected pulse %0d", k);
      end
      step();
      vectors++;
      if (frame_count !== 16'(k)) begin
        miscompares++;
        $display("FAIL frame_count: got %0d expected %0d", frame_count, k);
      end
    end
  endtask
`endif

  initial begin
    test_reset();
    test_line();
    test_sync();
    test_frames();
    test_mid_reset();
`ifdef VGA_TIMING_FRAME_COUNT_EN
    test_frame_count();
`endif
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
